// File: rtl/led_blink_pkg.sv
// Shared types and helpers for the multi-channel LED blinker.
// Channel mode encoding, burst count width and the reset half-period helper.
package led_blink_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_BURST = 2'd3
    } mode_e;

    localparam int CNT_W = 8;

    // Half of the clock rate gives a 1 Hz blink after reset.
    function automatic int default_half(input int clk_hz);
        return clk_hz / 2;
    endfunction

    // Channel select leaves room for codes >= nch so out-of-range writes can be expressed.
    function automatic int ch_width(input int nch);
        return (nch < 1) ? 1 : $clog2(nch + 1);
    endfunction

endpackage

// File: rtl/multi_led_blinker_if.sv
// Configuration write port of the LED blinker: valid/ready handshake plus payload.
interface multi_led_blinker_if
    import led_blink_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CPT_W = 25
);
    localparam int CH_W = ch_width(NCH);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [1:0]       cfg_mode;
    logic [CPT_W-1:0] cfg_half;
    logic [CNT_W-1:0] cfg_count;

    modport master (
        output cfg_valid, cfg_ch, cfg_mode, cfg_half, cfg_count,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_mode, cfg_half, cfg_count,
        output cfg_ready
    );

endinterface

// File: rtl/blink_channel.sv
// One LED channel: mode register, half-period counter, toggle and burst countdown.
//   mode       | meaning
//   MODE_OFF   | led held 0, counter idle
//   MODE_ON    | led held 1, counter idle
//   MODE_BLINK | led toggles every half_q cycles forever
//   MODE_BURST | as BLINK; each led fall consumes one pulse, last fall returns to OFF
module blink_channel
    import led_blink_pkg::*;
#(
    parameter int CPT_W        = 25,
    parameter int DEFAULT_HALF = 13_500_000
) (
    input  logic             fpga_CLK_AUX,
    input  logic             n_rst,
    input  logic             load_i,
    input  mode_e            mode_i,
    input  logic [CPT_W-1:0] half_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic             sync_i,
    output logic             led_o,
    output logic             tick_o,
    output logic             busy_o
);
    localparam logic [CPT_W-1:0] HALF_ONE = CPT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mode_e            mode_q, mode_d;
    logic [CPT_W-1:0] half_q, half_d;
    logic [CPT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             led_q, led_d;
    logic             tick_q, tick_d;
    logic             running;

    assign running = (mode_q == MODE_BLINK) || (mode_q == MODE_BURST);

    always_ff @(posedge fpga_CLK_AUX or negedge n_rst) begin
        if (!n_rst) begin
            mode_q <= MODE_OFF;
            half_q <= CPT_W'(DEFAULT_HALF);
            cnt_q  <= '0;
            rem_q  <= '0;
            led_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            half_q <= half_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            led_q  <= led_d;
            tick_q <= tick_d;
        end
    end

    always_comb begin
        mode_d = mode_q;
        half_d = half_q;
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        led_d  = led_q;
        tick_d = 1'b0;
        if (load_i) begin
            half_d = (half_i == '0) ? HALF_ONE : half_i;
            cnt_d  = '0;
            rem_d  = count_i;
            led_d  = (mode_i == MODE_ON);
            mode_d = (mode_i == MODE_BURST && count_i == '0) ? MODE_OFF : mode_i;
        end else if (running) begin
            if (sync_i) begin
                cnt_d = '0;
                led_d = 1'b0;
            end else if (cnt_q == half_q - HALF_ONE) begin
                cnt_d  = '0;
                led_d  = !led_q;
                tick_d = 1'b1;
                // A falling edge in BURST consumes one pulse; the last one ends the burst.
                if (mode_q == MODE_BURST && led_q) begin
                    rem_d = rem_q - CNT_ONE;
                    if (rem_q == CNT_ONE) begin
                        mode_d = MODE_OFF;
                    end
                end
            end else begin
                cnt_d = cnt_q + HALF_ONE;
            end
        end
    end

    assign led_o  = led_q;
    assign tick_o = tick_q;
    assign busy_o = (mode_q == MODE_BURST);

endmodule

// File: rtl/multi_led_blinker.sv
// N-channel LED blinker/divider: decodes configuration writes into per-channel load strobes.
module multi_led_blinker
    import led_blink_pkg::*;
#(
    parameter int NCH          = 4,
    parameter int CLK_HZ       = 27_000_000,
    parameter int CPT_W        = 25,
    parameter int DEFAULT_HALF = default_half(CLK_HZ)
) (
    input  logic                fpga_CLK_AUX,
    input  logic                n_rst,
    multi_led_blinker_if.slave  cfg,
    input  logic                sync_i,
    output logic [NCH-1:0]      led,
    output logic [NCH-1:0]      tick,
    output logic [NCH-1:0]      busy
);
    localparam int CH_W = ch_width(NCH);

    logic           cfg_accept;
    logic [NCH-1:0] load;

    // Realignment has priority over configuration writes.
    assign cfg.cfg_ready = !sync_i;
    assign cfg_accept    = cfg.cfg_valid && cfg.cfg_ready;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign load[i] = cfg_accept && (cfg.cfg_ch == CH_W'(i));

        blink_channel #(
            .CPT_W        (CPT_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_ch (
            .fpga_CLK_AUX (fpga_CLK_AUX),
            .n_rst        (n_rst),
            .load_i       (load[i]),
            .mode_i       (mode_e'(cfg.cfg_mode)),
            .half_i       (cfg.cfg_half),
            .count_i      (cfg.cfg_count),
            .sync_i       (sync_i),
            .led_o        (led[i]),
            .tick_o       (tick[i]),
            .busy_o       (busy[i])
        );
    end

endmodule
